// File: rtl/tinyqv_alu_sequencer_if.sv
// Bundle between the ALU sequencer, its requester and the nibble ALU/shifter.
// The slave side is the sequencer; the master side is the surrounding core.
interface tinyqv_alu_sequencer_if;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  alu_op;
   logic [3:0]  alu_a;
   logic [3:0]  alu_b;
   logic        alu_cy_in;
   logic        alu_cmp_in;
   logic [3:0]  alu_d;
   logic        alu_cy_out;
   logic        alu_cmp_res;
   logic [2:0]  counter;
   logic [3:0]  shift_d;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        cmp;

   modport slave (
      input  start, op, a, b,
      input  alu_d, alu_cy_out, alu_cmp_res, shift_d,
      output alu_op, alu_a, alu_b, alu_cy_in, alu_cmp_in,
      output counter, busy, done, result, cmp
   );

   modport master (
      output start, op, a, b,
      output alu_d, alu_cy_out, alu_cmp_res, shift_d,
      input  alu_op, alu_a, alu_b, alu_cy_in, alu_cmp_in,
      input  counter, busy, done, result, cmp
   );
endinterface

// File: rtl/tinyqv_alu_sequencer.sv
// Runs a 32-bit ALU/shift op through a 4-bit ALU, one nibble per cycle,
// LSB first, chaining carry and compare between nibbles.
module tinyqv_alu_sequencer (
   input logic                   clk,
   input logic                   rstn,
   tinyqv_alu_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        cy_q, cy_d;
   logic        cmpr_q, cmpr_d;
   logic [31:0] res_q, res_d;
   logic        cmp_q, cmp_d;

   logic        run;
   logic        is_slt;
   logic        is_shift;
   logic [4:0]  base;
   logic [3:0]  nib;

   assign run      = (state_q == S_RUN);
   assign is_slt   = (op_q[2:1] == 2'b01);
   assign is_shift = (op_q[1:0] == 2'b01);
   assign base     = {cnt_q, 2'b00};

   always_comb begin
      nib = bus.alu_d;
      if (is_slt)
         nib = 4'h0;
      else if (is_shift)
         nib = bus.shift_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      cy_d    = cy_q;
      cmpr_d  = cmpr_q;
      res_d   = res_q;
      cmp_d   = cmp_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_RUN;
               op_d    = bus.op;
               a_d     = bus.a;
               b_d     = bus.b;
               cnt_d   = 3'd0;
               res_d   = 32'h0;
               cy_d    = bus.op[1] | bus.op[3];
               cmpr_d  = 1'b1;
            end
         end
         S_RUN: begin
            cy_d              = bus.alu_cy_out;
            cmpr_d            = bus.alu_cmp_res;
            cnt_d             = cnt_q + 3'd1;
            res_d[base +: 4]  = nib;
            if (cnt_q == 3'd7) begin
               state_d = S_DONE;
               cmp_d   = bus.alu_cmp_res;
               // Set-less-than results are the final compare bit only.
               if (is_slt)
                  res_d = {31'h0, bus.alu_cmp_res};
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         op_q    <= 4'h0;
         a_q     <= 32'h0;
         b_q     <= 32'h0;
         cy_q    <= 1'b0;
         cmpr_q  <= 1'b1;
         res_q   <= 32'h0;
         cmp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cy_q    <= cy_d;
         cmpr_q  <= cmpr_d;
         res_q   <= res_d;
         cmp_q   <= cmp_d;
      end
   end

   assign bus.alu_op     = op_q;
   assign bus.alu_a      = run ? a_q[base +: 4] : 4'h0;
   assign bus.alu_b      = run ? b_q[base +: 4] : 4'h0;
   assign bus.alu_cy_in  = cy_q;
   assign bus.alu_cmp_in = cmpr_q;
   assign bus.counter    = run ? cnt_q : 3'd0;
   assign bus.busy       = run;
   assign bus.done       = (state_q == S_DONE);
   assign bus.result     = res_q;
   assign bus.cmp        = cmp_q;

endmodule

// File: tb/tb_tinyqv_alu_sequencer.sv
// Directed bench for the nibble-serial ALU sequencer with a behavioural
// nibble ALU and shifter attached.
module tb_tinyqv_alu_sequencer;

   logic clk;
   logic rstn;
   int   n_cmp;
   int   n_bad;

   logic [31:0] cur_a;
   logic [31:0] cur_b;

   tinyqv_alu_sequencer_if sq ();

   tinyqv_alu_sequencer dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (sq.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural nibble ALU.
   logic [4:0] sum;
   always_comb begin
      sum            = 5'h0;
      sq.alu_d       = 4'h0;
      sq.alu_cy_out  = 1'b0;
      sq.alu_cmp_res = sq.alu_cmp_in;
      case (sq.alu_op)
         4'b0000: begin
            sum           = {1'b0, sq.alu_a} + {1'b0, sq.alu_b}
                          + {4'h0, sq.alu_cy_in};
            sq.alu_d      = sum[3:0];
            sq.alu_cy_out = sum[4];
         end
         4'b1000, 4'b0010, 4'b0011: begin
            sum           = {1'b0, sq.alu_a} + {1'b0, ~sq.alu_b}
                          + {4'h0, sq.alu_cy_in};
            sq.alu_d      = sum[3:0];
            sq.alu_cy_out = sum[4];
            if (sq.alu_op == 4'b0010 && (sq.alu_a[3] ^ sq.alu_b[3]))
               sq.alu_cmp_res = sq.alu_a[3];
            else
               sq.alu_cmp_res = ~sum[4];
         end
         4'b0100: begin
            sq.alu_d       = sq.alu_a ^ sq.alu_b;
            sq.alu_cmp_res = sq.alu_cmp_in
                           & ((sq.alu_a ^ sq.alu_b) == 4'h0);
         end
         4'b0110: sq.alu_d = sq.alu_a | sq.alu_b;
         4'b0111: sq.alu_d = sq.alu_a & sq.alu_b;
         default: sq.alu_d = 4'h0;
      endcase
   end

   // Behavioural shifter working from the bench's copy of the operands.
   logic [31:0] shf;
   always_comb begin
      case (sq.alu_op)
         4'b0001: shf = cur_a << cur_b[4:0];
         4'b0101: shf = cur_a >> cur_b[4:0];
         4'b1101: shf = $unsigned($signed(cur_a) >>> cur_b[4:0]);
         default: shf = 32'h0;
      endcase
      sq.shift_d = shf[{sq.counter, 2'b00} +: 4];
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   typedef struct {
      string       nm;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        cmp;
      logic        cc;
   } vec_t;

   task automatic run_op(input string nm, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic cmp,
                         input logic cc);
      int   cyc;
      int   idx;
      logic seq_ok;
      @(negedge clk);
      cur_a    = a;
      cur_b    = b;
      sq.op    = op;
      sq.a     = a;
      sq.b     = b;
      sq.start = 1'b1;
      @(negedge clk);
      sq.start = 1'b0;
      chk({nm, " cy_init"}, {31'h0, sq.alu_cy_in}, {31'h0, op[1] | op[3]});
      chk({nm, " cmp_init"}, {31'h0, sq.alu_cmp_in}, 32'h1);
      chk({nm, " alu_op"}, {28'h0, sq.alu_op}, {28'h0, op});
      cyc    = 1;
      idx    = 0;
      seq_ok = 1'b1;
      while (!sq.done && cyc < 20) begin
         if (!sq.busy || sq.counter != idx[2:0]
             || sq.alu_a != a[4*idx +: 4]
             || sq.alu_b != b[4*idx +: 4])
            seq_ok = 1'b0;
         idx++;
         @(negedge clk);
         cyc++;
      end
      chk({nm, " run_seq"}, {31'h0, seq_ok}, 32'h1);
      chk({nm, " latency"}, cyc, 32'd9);
      chk({nm, " result"}, sq.result, res);
      if (cc)
         chk({nm, " cmp"}, {31'h0, sq.cmp}, {31'h0, cmp});
      chk({nm, " done_idle"},
          {23'h0, sq.busy, sq.counter, sq.alu_a}, 32'h0);
      @(negedge clk);
      chk({nm, " done_pulse"}, {31'h0, sq.done}, 32'h0);
      chk({nm, " hold"}, sq.result, res);
   endtask

   vec_t vt[14];
   int   cyc;
   logic ok;

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      cur_a    = 32'h0;
      cur_b    = 32'h0;
      sq.start = 1'b0;
      sq.op    = 4'h0;
      sq.a     = 32'h0;
      sq.b     = 32'h0;

      vt[0]  = '{"add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0};
      vt[1]  = '{"sub", 4'b1000, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vt[2]  = '{"slt", 4'b0010, 32'h8000_0000, 32'h1, 32'h1, 1'b1, 1'b1};
      vt[3]  = '{"sltu", 4'b0011, 32'h8000_0000, 32'h1, 32'h0, 1'b0, 1'b1};
      vt[4]  = '{"eq", 4'b0100, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b1, 1'b1};
      vt[5]  = '{"neq", 4'b0100, 32'h1234_5678, 32'h9234_5678,
                 32'h8000_0000, 1'b0, 1'b1};
      vt[6]  = '{"sra", 4'b1101, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, 1'b0};
      vt[7]  = '{"sll", 4'b0001, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 1'b0};
      vt[8]  = '{"srl", 4'b0101, 32'h8000_0000, 32'h4, 32'h0800_0000, 1'b0, 1'b0};
      vt[9]  = '{"and", 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00,
                 32'hF000_F000, 1'b0, 1'b0};
      vt[10] = '{"or", 4'b0110, 32'h0F0F_0000, 32'h0000_00F0,
                 32'h0F0F_00F0, 1'b0, 1'b0};
      vt[11] = '{"slt_neg", 4'b0010, 32'h5, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1};
      vt[12] = '{"sltu_big", 4'b0011, 32'h5, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1};
      vt[13] = '{"add_carry", 4'b0000, 32'h0000_FFFF, 32'h0000_0001,
                 32'h0001_0000, 1'b0, 1'b0};

      rstn = 1'b1;
      #1 rstn = 1'b0;
      #2;
      chk("rst_outs", {27'h0, sq.busy, sq.done, sq.counter},
          32'h0);
      chk("rst_result", sq.result, 32'h0);
      chk("rst_flags", {28'h0, sq.alu_cy_in, sq.alu_cmp_in, sq.cmp, 1'b0},
          32'h4);
      chk("rst_alu_op", {28'h0, sq.alu_op}, 32'h0);
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 14; i++)
         run_op(vt[i].nm, vt[i].op, vt[i].a, vt[i].b,
                vt[i].res, vt[i].cmp, vt[i].cc);

      // Start held high through DONE, with op changing mid-run.
      @(negedge clk);
      cur_a    = 32'h10;
      cur_b    = 32'h0E;
      sq.op    = 4'b0000;
      sq.a     = 32'h10;
      sq.b     = 32'h0E;
      sq.start = 1'b1;
      @(negedge clk);
      sq.op = 4'b1000;
      cyc   = 1;
      while (!sq.done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("held latency", cyc, 32'd9);
      chk("held result", sq.result, 32'h1E);
      sq.op = 4'b0000;
      sq.a  = 32'h1;
      sq.b  = 32'h1;
      cur_a = 32'h1;
      cur_b = 32'h1;
      @(negedge clk);
      chk("held idle", {30'h0, sq.busy, sq.done}, 32'h0);
      chk("held stable", sq.result, 32'h1E);
      @(negedge clk);
      sq.start = 1'b0;
      chk("held accept", {28'h0, sq.busy, sq.counter}, 32'h8);
      cyc = 1;
      while (!sq.done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("held2 latency", cyc, 32'd9);
      chk("held2 result", sq.result, 32'h2);

      // Reset in the middle of a run.
      @(negedge clk);
      cur_a    = 32'h1111_1111;
      cur_b    = 32'h2222_2222;
      sq.a     = cur_a;
      sq.b     = cur_b;
      sq.op    = 4'b0000;
      sq.start = 1'b1;
      @(negedge clk);
      sq.start = 1'b0;
      cyc = 0;
      while (sq.counter != 3'd3 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("mid counter", {29'h0, sq.counter}, 32'd3);
      #2 rstn = 1'b0;
      #1;
      chk("mid rst outs", {27'h0, sq.busy, sq.done, sq.counter}, 32'h0);
      chk("mid rst result", sq.result, 32'h0);
      chk("mid rst flags", {29'h0, sq.alu_cy_in, sq.alu_cmp_in, sq.cmp},
          32'h2);
      ok = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (sq.done || sq.busy)
            ok = 1'b0;
      end
      rstn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (sq.done || sq.busy)
            ok = 1'b0;
      end
      chk("mid no done", {31'h0, ok}, 32'h1);
      run_op("post_rst_add", 4'b0000, 32'h2, 32'h3, 32'h5, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
